// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider.
// The core drives the master side; div_seq sits on the slave side.
interface div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro DIV_SEQ_SHORTCUT_EN: finish at once when |divisor| > |dividend|.
module div_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g, p, gg, pp, ng, np;
    logic [32:0] c;

    // Kogge-Stone prefix tree over generate/propagate pairs
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = g;
        pp = p;
        ng = '0;
        np = '0;
        c  = '0;
        for (int lvl = 0; lvl < 5; lvl++) begin
            ng = gg;
            np = pp;
            for (int i = (1 << lvl); i < 32; i++) begin
                ng[i] = gg[i] | (pp[i] & gg[i - (1 << lvl)]);
                np[i] = pp[i] & pp[i - (1 << lvl)];
            end
            gg = ng;
            pp = np;
        end
        c[0] = cin;
        for (int i = 1; i < 33; i++) begin
            c[i] = gg[i-1] | (pp[i-1] & cin);
        end
        sum  = p ^ c[31:0];
        cout = c[32];
    end
endmodule

module div_seq #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);
    localparam int S = STEPS_PER_CYCLE;
    localparam int N = 32 / S;
    localparam logic [4:0] LAST = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt;
    logic [31:0] rem_q, dvd_q, dsr_q;
    logic        neg_q, neg_r;
    logic [31:0] quo_q, rmd_q;

    logic        accept, last;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, ovf, early, special;
    logic [31:0] q_sp, r_sp, q_fin, r_fin;

    logic [S:0][31:0] rem_c, dvd_c;

    assign accept = (state == IDLE) & bus.in_valid;
    assign last   = (cnt == LAST);

    assign a_neg = bus.is_signed & bus.dividend[31];
    assign b_neg = bus.is_signed & bus.divisor[31];
    assign mag_a = a_neg ? -bus.dividend : bus.dividend;
    assign mag_b = b_neg ? -bus.divisor : bus.divisor;

    assign div_zero = (bus.divisor == 32'd0);
    assign ovf      = bus.is_signed
                    & (bus.dividend == 32'h8000_0000)
                    & (bus.divisor == 32'hFFFF_FFFF);
`ifdef DIV_SEQ_SHORTCUT_EN
    assign early = (mag_b > mag_a);
`else
    assign early = 1'b0;
`endif
    assign special = div_zero | ovf | early;

    assign q_sp = div_zero ? 32'hFFFF_FFFF
                : ovf      ? 32'h8000_0000
                :            32'd0;
    assign r_sp = ovf ? 32'd0 : bus.dividend;

    assign rem_c[0] = rem_q;
    assign dvd_c[0] = dvd_q;

    // rem[31] set means the shifted value overflowed 32 bits, so it must exceed the divisor
    for (genvar s = 0; s < S; s++) begin : g_step
        logic [31:0] sh, diff;
        logic        co, ge;
        assign sh = {rem_c[s][30:0], dvd_c[s][31]};
        div_cla32 u_add (
            .a    (sh),
            .b    (~dsr_q),
            .cin  (1'b1),
            .sum  (diff),
            .cout (co)
        );
        assign ge         = rem_c[s][31] | co;
        assign rem_c[s+1] = ge ? diff : sh;
        assign dvd_c[s+1] = {dvd_c[s][30:0], ge};
    end

    assign q_fin = neg_q ? -dvd_c[S] : dvd_c[S];
    assign r_fin = neg_r ? -rem_c[S] : rem_c[S];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (bus.in_valid) state_n = special ? DONE : RUN;
            RUN:  if (last)          state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            rem_q <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            quo_q <= '0;
            rmd_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            rem_q <= '0;
            dvd_q <= mag_a;
            dsr_q <= mag_b;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (special) begin
                quo_q <= q_sp;
                rmd_q <= r_sp;
            end
        end else if (state == RUN) begin
            rem_q <= rem_c[S];
            dvd_q <= dvd_c[S];
            cnt   <= cnt + 5'd1;
            if (last) begin
                cnt   <= '0;
                quo_q <= q_fin;
                rmd_q <= r_fin;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed + scoreboard bench for div_seq, one instance per STEPS_PER_CYCLE.
// Expected results come from spec constants or an integer model of RV32M division.
module tb_div_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dividend, divisor;
    logic        is_signed, out_ready;
    logic        iv1, iv2;
    int          sel;
    int          ntest = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    div_seq_if bus1 ();
    div_seq_if bus2 ();

    assign bus1.in_valid  = iv1;
    assign bus1.dividend  = dividend;
    assign bus1.divisor   = divisor;
    assign bus1.is_signed = is_signed;
    assign bus1.out_ready = out_ready;
    assign bus2.in_valid  = iv2;
    assign bus2.dividend  = dividend;
    assign bus2.divisor   = divisor;
    assign bus2.is_signed = is_signed;
    assign bus2.out_ready = out_ready;

    div_seq #(.STEPS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    div_seq #(.STEPS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    logic        o_valid, o_rdy;
    logic [31:0] o_q, o_r;
    assign o_valid = (sel == 2) ? bus2.out_valid : bus1.out_valid;
    assign o_rdy   = (sel == 2) ? bus2.in_ready  : bus1.in_ready;
    assign o_q     = (sel == 2) ? bus2.quotient  : bus1.quotient;
    assign o_r     = (sel == 2) ? bus2.remainder : bus1.remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  input int steps);
        if (b == 0) return 1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_SEQ_SHORTCUT_EN
        begin
            logic [31:0] ma, mb;
            ma = (s && a[31]) ? -a : a;
            mb = (s && b[31]) ? -b : b;
            if (mb > ma) return 1;
        end
`endif
        return 32 / steps;
    endfunction

    task automatic issue(input int which, input logic [31:0] a, input logic [31:0] b,
                         input bit s, input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        sel = which;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        if (which == 2) iv2 = 1'b1;
        else            iv1 = 1'b1;
        #1;
        chk("in_ready_before_accept", o_rdy, 1);
        @(posedge clk);
        #1;
        iv1 = 1'b0;
        iv2 = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        e.q   = q;
        e.r   = r;
        e.lat = lat_of(a, b, s, which);
        sb.push_back(e);
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   k;
        bit   rdy_bad;
        k = 0;
        rdy_bad = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
            if (o_rdy) rdy_bad = 1;
        end while (!o_valid && k < 200);
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_busy_in_ready"}, rdy_bad, 0);
        chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.q = 'x; e.r = 'x; e.lat = -1;
        end
        chk({tag, "_latency"}, k, e.lat);
        chk({tag, "_quotient"}, o_q, e.q);
        chk({tag, "_remainder"}, o_r, e.r);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            dividend  = $urandom;
            divisor   = $urandom;
            is_signed = 1'b1;
            if (sel == 2) iv2 = 1'b1;
            else          iv1 = 1'b1;
            @(posedge clk);
            #1;
            iv1 = 1'b0;
            iv2 = 1'b0;
            chk({tag, "_hold_valid"}, o_valid, 1);
            chk({tag, "_hold_in_ready"}, o_rdy, 0);
            chk({tag, "_hold_quotient"}, o_q, e.q);
            chk({tag, "_hold_remainder"}, o_r, e.r);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_retire_valid"}, o_valid, 0);
        chk({tag, "_retire_in_ready"}, o_rdy, 1);
    endtask

    task automatic run_rand(input int which, input int n);
        logic [31:0] a, b, q, r;
        bit          s;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            s = 1'($urandom_range(0, 1));
            model(a, b, s, q, r);
            issue(which, a, b, s, q, r);
            collect("rand", 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        iv1 = 1'b0;
        iv2 = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        sel = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", o_valid, 0);
        chk("reset_quotient", o_q, 0);
        chk("reset_remainder", o_r, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", o_rdy, 1);

        for (int w = 1; w <= 2; w++) begin
            issue(w, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
            collect("u100_7", 0);
            issue(w, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
            collect("sneg7_2", 0);
            issue(w, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
            collect("s7_neg2", 0);
            issue(w, 32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234);
            collect("sdivzero", 0);
            issue(w, 32'h1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234);
            collect("udivzero", 0);
            issue(w, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
            collect("sovf", 0);
            issue(w, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
            collect("ubig_div", 0);
            issue(w, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE);
            collect("uwide_rem", 0);
            run_rand(w, 4);
        end

        issue(1, 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6);
        collect("backpressure", 5);

        issue(1, 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", o_valid, 0);
        chk("midrun_rst_quotient", o_q, 0);
        chk("midrun_rst_remainder", o_r, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", o_rdy, 1);
        issue(1, 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
        collect("post_rst_9_3", 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
